fp_div_recip: RTL and testbench
===============================

// Module: fp_div_recip
// PURPOSE
//   IEEE-754 single-precision divider q = a / b built as a * (1/b). Sits downstream of the
//   reciprocal CORDIC unit: requests 1/b over a start/done handshake, then multiplies and
//   normalises. The reciprocal unit is external; this block owns only its request/response port.
// PARAMETERS
//   EXP_W       8    exponent field width
//   MAN_W       23   stored mantissa width (hidden bit implicit)
//   WAIT_LIMIT  64   max cycles in WAIT before timeout abort; 0 = watchdog disabled
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   start        in   1   1-cycle request; sampled only in IDLE
//   a            in   32  dividend
//   b            in   32  divisor
//   quotient     out  32  result, held until next accepted start
//   done         out  1   1-cycle pulse, quotient valid from this cycle
//   busy         out  1   high from the cycle after an accepted start until the cycle after done
//   div_by_zero  out  1   sticky per op; set with done when recip_zero seen
//   timeout      out  1   sticky per op; set with done on watchdog expiry
//   recip_start  out  1   1-cycle request to reciprocal unit
//   recip_x      out  32  operand to reciprocal unit (= latched b)
//   recip_out    in   32  reciprocal result, valid when recip_done=1
//   recip_done   in   1   reciprocal completion pulse
//   recip_zero   in   1   reciprocal input was zero; valid with recip_done
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, watchdog=0. Reset mid-op aborts; recip_done arriving later ignored.
//   FSM: IDLE -start-> REQ -> WAIT -recip_done-> MUL -> NORM -> FIN -> IDLE.
//     IDLE: on start latch a,b; clear flags. start while busy ignored.
//     REQ:  recip_start=1 exactly one cycle; recip_x=b_reg (held stable through WAIT).
//     WAIT: watchdog counts; recip_done latches recip_out/recip_zero. If recip_done and watchdog
//           expiry coincide, recip_done wins. Expiry -> FIN with quotient=0x7FC00000, timeout=1.
//     MUL:  24x24 unsigned product of {1,man_a}*{1,man_r} into 48-bit register.
//     NORM: sign=sa^sr; exp=ea+er-127 (10-bit signed); if prod[47] shift right 1, exp+1.
//     FIN:  quotient registered, done=1. Latency start->done = 5 + reciprocal latency.
//   Special cases (priority order, resolved in NORM/FIN):
//     recip_zero=1            -> {sa^sb,8'hFF,23'h0}, div_by_zero=1
//     a exp field 8'hFF       -> 0x7FC00000 (inf/NaN dividend unsupported, canonical NaN)
//     a exp field 0           -> {sign,31'h0} (denormals flushed to zero)
//     exp >= 255 after round  -> {sign,8'hFF,23'h0} overflow to inf
//     exp <= 0                -> {sign,31'h0} underflow flushed
//   Rounding carry out of mantissa (1.111..+ulp) renormalises: mantissa=0, exp+1, re-check overflow.
// CONFIGURATION
//   FP_DIV_RNE_EN defined: round-to-nearest-even using guard bit + sticky OR of lower product bits.
//   Not defined: truncate (round toward zero); guard/sticky logic not generated. Latency identical.
// STRUCTURE
//   Package fp_div_pkg: EXP_W/MAN_W/BIAS(127) constants, QNAN=32'h7FC00000, field-extract
//   functions, state enum {IDLE,REQ,WAIT,MUL,NORM,FIN}.
//   Sub-module fp_mant_mul_norm: registered 24x24 multiply + normalise/round; FSM and
//   special-case muxing stay in top level.
// TESTING (reciprocal unit modelled by bench responder with programmable latency)
//   1. a=0x40400000, b=0x40000000, recip_out=0x3F000000 after 20 cy -> quotient 0x3FC00000,
//      done exactly 25 cy after start, flags 0.
//   2. b=0x00000000, responder recip_zero=1, a=0xC0000000 -> quotient 0xFF800000, div_by_zero=1.
//   3. a=0x3FC00001, recip_out=0x3FC00000 -> 0x40100000 without FP_DIV_RNE_EN, 0x40100001 with.
//   4. a=0x7F000000, recip_out=0x7E800000 -> 0x7F800000 (overflow); a=0x00800000,
//      recip_out=0x00800000 -> 0x00000000 (underflow).
//   5. WAIT_LIMIT=16, responder silent -> done 16 cy after entering WAIT, quotient 0x7FC00000,
//      timeout=1; start pulses during busy produce no extra recip_start.
//   6. rst low during WAIT, late recip_done after release -> no done, outputs 0, next op normal.

Source files
------------

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants, IEEE-754 field helpers and FSM state type for fp_div_recip.
package fp_div_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, MUL, NORM, FIN} state_e;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f_man(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_mant_mul_norm.sv
// fp_mant_mul_norm: registered 24x24 mantissa multiply, then registered normalise and round.
// FP_DIV_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_mant_mul_norm #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mul_en,
    input  logic               norm_en,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [MAN_W-1:0]   man_r,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_r,
    output logic [EXP_W+1:0]   exp_n,
    output logic [MAN_W-1:0]   man_n
);
    import fp_div_pkg::*;

    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;

    logic [PW-1:0]    prod_q, prod_d;
    logic [MAN_W-1:0] man_q, man_d, man_t;
    logic [XW-1:0]    exp_q, exp_d, exp_t;
    logic             hi;
`ifdef FP_DIV_RNE_EN
    logic             grd, stk;
    logic [MAN_W:0]   sum;
`endif

    always_comb begin
        prod_d = mul_en ? PW'({1'b1, man_a}) * PW'({1'b1, man_r}) : prod_q;
        hi     = prod_q[PW-1];
        man_t  = MAN_W'(hi ? prod_q >> (MAN_W + 1) : prod_q >> MAN_W);
        // two's-complement exponent; the top bit flags underflow below zero
        exp_t  = XW'(exp_a) + XW'(exp_r) - XW'(BIAS) + XW'(hi);
`ifdef FP_DIV_RNE_EN
        grd    = hi ? prod_q[MAN_W] : prod_q[MAN_W-1];
        stk    = |(hi ? prod_q << (PW - MAN_W) : prod_q << (PW - MAN_W + 1));
        sum    = {1'b0, man_t} + (MAN_W + 1)'(grd & (stk | man_t[0]));
        man_d  = norm_en ? sum[MAN_W-1:0] : man_q;
        exp_d  = norm_en ? exp_t + XW'(sum[MAN_W]) : exp_q;
`else
        man_d  = norm_en ? man_t : man_q;
        exp_d  = norm_en ? exp_t : exp_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
            man_q  <= '0;
            exp_q  <= '0;
        end else begin
            prod_q <= prod_d;
            man_q  <= man_d;
            exp_q  <= exp_d;
        end
    end

    assign exp_n = exp_q;
    assign man_n = man_q;

endmodule

// File: rtl/fp_div_recip.sv
// fp_div_recip: single-precision q = a / b computed as a * (1/b) from an external reciprocal unit.
// Build option FP_DIV_RNE_EN enables round-to-nearest-even; default build truncates.
module fp_div_recip #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   quotient,
    output logic                   done,
    output logic                   busy,
    output logic                   div_by_zero,
    output logic                   timeout,
    output logic                   recip_start,
    output logic [EXP_W+MAN_W:0]   recip_x,
    input  logic [EXP_W+MAN_W:0]   recip_out,
    input  logic                   recip_done,
    input  logic                   recip_zero
);
    import fp_div_pkg::*;

    localparam int W    = EXP_W + MAN_W + 1;
    localparam int WD_W = $clog2(WAIT_LIMIT + 2);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, r_q, r_d, quo_q, quo_d, res;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             rz_q, rz_d, tmo_q, tmo_d, done_q, done_d, busy_q, busy_d;
    logic             dz_q, dz_d, to_q, to_d;
    logic [EXP_W+1:0] exp_n;
    logic [MAN_W-1:0] man_n;
    logic             sign, ovf, unf, wd_exp;

    fp_mant_mul_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .mul_en  (state_q == MUL),
        .norm_en (state_q == NORM),
        .man_a   (f_man(a_q)),
        .man_r   (f_man(r_q)),
        .exp_a   (f_exp(a_q)),
        .exp_r   (f_exp(r_q)),
        .exp_n   (exp_n),
        .man_n   (man_n)
    );

    // the watchdog count includes the FIN cycle, so done lands WAIT_LIMIT cycles after WAIT entry
    assign wd_exp = (WAIT_LIMIT != 0) && (32'(wd_q) + 32'd2 >= 32'(WAIT_LIMIT));

    always_comb begin
        sign = f_sign(a_q) ^ f_sign(r_q);
        ovf  = !exp_n[EXP_W+1] && (exp_n[EXP_W] || &exp_n[EXP_W-1:0]);
        unf  = exp_n[EXP_W+1] || ~|exp_n;
        res  = tmo_q            ? QNAN :
               rz_q             ? {f_sign(a_q) ^ f_sign(b_q), {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               &f_exp(a_q)      ? QNAN :
               ~|f_exp(a_q)     ? {sign, {(W-1){1'b0}}} :
               ovf              ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               unf              ? {sign, {(W-1){1'b0}}} :
                                  {sign, exp_n[EXP_W-1:0], man_n};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        rz_d    = rz_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        busy_d  = busy_q & ~done_q;
        dz_d    = dz_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: if (start && !busy_q) begin
                state_d = REQ;
                a_d     = a;
                b_d     = b;
                rz_d    = 1'b0;
                tmo_d   = 1'b0;
                dz_d    = 1'b0;
                to_d    = 1'b0;
                busy_d  = 1'b1;
            end
            REQ: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: if (recip_done) begin
                state_d = MUL;
                r_d     = recip_out;
                rz_d    = recip_zero;
            end else if (wd_exp) begin
                state_d = FIN;
                tmo_d   = 1'b1;
            end else begin
                wd_d    = wd_q + 1'b1;
            end
            MUL:  state_d = NORM;
            NORM: state_d = FIN;
            FIN: begin
                state_d = IDLE;
                quo_d   = res;
                done_d  = 1'b1;
                dz_d    = rz_q;
                to_d    = tmo_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            rz_q    <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            rz_q    <= rz_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
        end
    end

    assign quotient    = quo_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dz_q;
    assign timeout     = to_q;
    assign recip_start = (state_q == REQ);
    assign recip_x     = b_q;

endmodule

// File: tb/tb_fp_div_recip.sv
// tb_fp_div_recip: directed checks of fp_div_recip with a programmable-latency reciprocal responder.
// Expectations for rounding cases follow FP_DIV_RNE_EN.
module tb_fp_div_recip;

`ifdef FP_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start_wd = 1'b0;
    logic        recip_done = 1'b0, recip_zero = 1'b0;
    logic [31:0] a = '0, b = '0, recip_out = '0;

    logic [31:0] q, rx, wq, wrx;
    logic        done_o, busy, dz, to, rs;
    logic        wdone, wbusy, wdz, wto, wrs;

    fp_div_recip u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .quotient(q), .done(done_o), .busy(busy), .div_by_zero(dz), .timeout(to),
        .recip_start(rs), .recip_x(rx), .recip_out(recip_out),
        .recip_done(recip_done), .recip_zero(recip_zero)
    );

    fp_div_recip #(.WAIT_LIMIT(16)) u_wd (
        .clk(clk), .rst(rst), .start(start_wd), .a(a), .b(b),
        .quotient(wq), .done(wdone), .busy(wbusy), .div_by_zero(wdz), .timeout(wto),
        .recip_start(wrs), .recip_x(wrx), .recip_out(recip_out),
        .recip_done(recip_done), .recip_zero(recip_zero)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rs_cnt = 0, rs_wd_cnt = 0, done_cnt = 0;

    always @(posedge clk) begin
        if (rs) rs_cnt <= rs_cnt + 1;
        if (wrs) rs_wd_cnt <= rs_wd_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    // reciprocal unit model: answers u_dut's request resp_lat edges after seeing recip_start
    logic        resp_en = 1'b1, resp_zero = 1'b0;
    int          resp_lat = 3;
    logic [31:0] resp_val = '0;

    initial forever begin
        @(posedge clk);
        if (rs && resp_en) begin
            repeat (resp_lat) @(posedge clk);
            #1;
            recip_done = 1'b1;
            recip_out  = resp_val;
            recip_zero = resp_zero;
            @(posedge clk);
            #1;
            recip_done = 1'b0;
            recip_zero = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [31:0] ta, input logic [31:0] tb_b, input logic [31:0] rv,
                      input logic rzv, input int lat, output int n);
        resp_val  = rv;
        resp_zero = rzv;
        resp_lat  = lat;
        resp_en   = 1'b1;
        a         = ta;
        b         = tb_b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done_o && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    logic [31:0] va [12] = '{32'hC0000000, 32'h3FC00001, 32'h3FFFFFFE, 32'h7F000000,
                             32'h00800000, 32'h7F000000, 32'h7F000000, 32'h00800000,
                             32'h00800000, 32'h7F800000, 32'h80000001, 32'hC0400000};
    logic [31:0] vb [12] = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000};
    logic [31:0] vr [12] = '{32'h7F800000, 32'h3FC00000, 32'h3F800001, 32'h7E800000,
                             32'h00800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                             32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h3E800000};
    logic        vz [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] vq [12] = '{32'hFF800000, RNE ? 32'h40100001 : 32'h40100000,
                             RNE ? 32'h40000000 : 32'h3FFFFFFF, 32'h7F800000,
                             32'h00000000, 32'h7F000000, 32'h7F800000, 32'h00800000,
                             32'h00000000, 32'h7FC00000, 32'h80000000, 32'hBF400000};

    initial begin
        int n, c0;
        #1 rst = 1'b0;
        #2;
        chk("rst_q", q, 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flags", {30'h0, dz, to}, 32'h0);
        chk("rst_rstart", 32'(rs), 32'h0);
        chk("rst_rx", rx, 32'h0);
        chk("rst_wq", wq, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        c0 = rs_cnt;
        op(32'h40400000, 32'h40000000, 32'h3F000000, 1'b0, 20, n);
        chk("t1_latency", 32'(n), 32'd25);
        chk("t1_q", q, 32'h3FC00000);
        chk("t1_flags", {30'h0, dz, to}, 32'h0);
        chk("t1_busy_at_done", 32'(busy), 32'h1);
        chk("t1_rstart_cnt", 32'(rs_cnt - c0), 32'd1);
        chk("t1_rx", rx, 32'h40000000);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", 32'(done_o), 32'h0);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_q_held", q, 32'h3FC00000);

        for (int i = 0; i < 12; i++) begin
            op(va[i], vb[i], vr[i], vz[i], 3, n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'd8);
            chk($sformatf("v%0d_q", i), q, vq[i]);
            chk($sformatf("v%0d_dz", i), 32'(dz), 32'(vz[i]));
            chk($sformatf("v%0d_to", i), 32'(to), 32'h0);
            @(posedge clk);
            #1;
        end

        resp_en = 1'b0;
        c0 = rs_wd_cnt;
        a = 32'h40400000;
        b = 32'h40000000;
        start_wd = 1'b1;
        @(posedge clk);
        #1 start_wd = 1'b0;
        n = 0;
        while (!wdone && n < 100) begin
            @(posedge clk);
            #1 n++;
            start_wd = (n == 3 || n == 6 || n == 10);
        end
        start_wd = 1'b0;
        chk("wd_latency", 32'(n), 32'd17);
        chk("wd_q", wq, 32'h7FC00000);
        chk("wd_timeout", 32'(wto), 32'h1);
        chk("wd_dz", 32'(wdz), 32'h0);
        chk("wd_rstart_cnt", 32'(rs_wd_cnt - c0), 32'd1);
        chk("wd_rx", wrx, 32'h40000000);
        @(posedge clk);
        #1;
        chk("wd_busy_after", 32'(wbusy), 32'h0);
        chk("wd_rstart_after", 32'(rs_wd_cnt - c0), 32'd1);

        resp_en  = 1'b1;
        resp_lat = 10;
        resp_val = 32'h3F000000;
        c0 = done_cnt;
        a = 32'h40400000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_q", q, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_rx", rx, 32'h0);
        chk("mid_rst_flags", {30'h0, dz, to}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("late_done_ignored", 32'(done_cnt - c0), 32'd0);
        chk("late_busy", 32'(busy), 32'h0);
        chk("late_q", q, 32'h0);
        op(32'h40400000, 32'h40000000, 32'h3F000000, 1'b0, 3, n);
        chk("post_rst_latency", 32'(n), 32'd8);
        chk("post_rst_q", q, 32'h3FC00000);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
